// File: rtl/frame_buffer_scheduler.sv
// Ping-pong frame-buffer scheduler: discards sensor settle frames, gates capture
// into the buffer not being displayed, and swaps buffers at display frame boundaries.
module frame_buffer_scheduler #(
  parameter int unsigned SKIP_FRAMES = 3,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             cam_vsync_rise,
  input  logic             cam_frame_done,
  input  logic             lcd_frame_done,
  output logic             frame_enable,
  output logic             cap_en,
  output logic             cap_restart,
  output logic             wr_buf_sel,
  output logic             rd_buf_sel,
  output logic             rd_valid,
  output logic             frame_swap,
  output logic [CNT_W-1:0] dropped_cnt
);

  typedef enum logic [1:0] {SETTLE, IDLE, CAPTURE, DROP} state_t;

  localparam logic [8:0] SKIP_W = 9'(SKIP_FRAMES);

  state_t             state, state_n;
  logic [7:0]         settle_cnt, settle_cnt_n;
  logic [8:0]         settle_sum;
  logic               pending, pending_n;
  logic               frame_enable_n;
  logic               cap_en_n;
  logic               cap_restart_n;
  logic               rd_buf_sel_n;
  logic               rd_valid_n;
  logic               swap;
  logic               drop_inc;
  logic [CNT_W-1:0]   dropped_cnt_n;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state        <= SETTLE;
      settle_cnt   <= '0;
      pending      <= 1'b0;
      frame_enable <= 1'b0;
      cap_en       <= 1'b0;
      cap_restart  <= 1'b0;
      rd_buf_sel   <= 1'b0;
      wr_buf_sel   <= 1'b1;
      rd_valid     <= 1'b0;
      frame_swap   <= 1'b0;
      dropped_cnt  <= '0;
    end else begin
      state        <= state_n;
      settle_cnt   <= settle_cnt_n;
      pending      <= pending_n;
      frame_enable <= frame_enable_n;
      cap_en       <= cap_en_n;
      cap_restart  <= cap_restart_n;
      rd_buf_sel   <= rd_buf_sel_n;
      wr_buf_sel   <= ~rd_buf_sel_n;
      rd_valid     <= rd_valid_n;
      frame_swap   <= swap;
      dropped_cnt  <= dropped_cnt_n;
    end
  end

  always_comb begin
    state_n        = state;
    settle_cnt_n   = settle_cnt;
    frame_enable_n = frame_enable;
    cap_en_n       = cap_en;
    cap_restart_n  = 1'b0;
    pending_n      = pending;
    drop_inc       = 1'b0;
    // Swap decision uses pending as it stood before this cycle's capture update.
    swap           = lcd_frame_done & pending;
    settle_sum     = {1'b0, settle_cnt} + {8'd0, cam_frame_done};

    unique case (state)
      SETTLE: begin
        settle_cnt_n = settle_sum[7:0];
        if (settle_sum >= SKIP_W) begin
          state_n        = IDLE;
          frame_enable_n = 1'b1;
        end
      end
      IDLE: begin
        if (cam_vsync_rise) begin
          if (pending) begin
            state_n  = DROP;
            drop_inc = 1'b1;
          end else begin
            state_n       = CAPTURE;
            cap_en_n      = 1'b1;
            cap_restart_n = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (cam_frame_done) begin
          state_n   = IDLE;
          cap_en_n  = 1'b0;
          pending_n = 1'b1;
          drop_inc  = cam_vsync_rise;
        end else if (cam_vsync_rise) begin
          cap_restart_n = 1'b1;
          drop_inc      = 1'b1;
        end
      end
      DROP: begin
        if (cam_frame_done) begin
          state_n  = IDLE;
          drop_inc = cam_vsync_rise;
        end else if (cam_vsync_rise) begin
          drop_inc = 1'b1;
        end
      end
      default: state_n = SETTLE;
    endcase

    if (swap) pending_n = 1'b0;

    rd_buf_sel_n  = rd_buf_sel ^ swap;
    rd_valid_n    = rd_valid | swap;
    dropped_cnt_n = (drop_inc && (dropped_cnt != '1)) ? dropped_cnt + CNT_W'(1) : dropped_cnt;
  end

endmodule
